// File: rtl/divide_by_n_fsm.sv
// Runtime-programmable clock divider: pulse or near-50% square output, terminal-count
// strobe and live phase count. Ratio/mode are shadow-loaded only on period wrap.
module divide_by_n_fsm #(
  parameter int WIDTH        = 8,
  parameter int DEFAULT_DIV  = 4,
  parameter int DEFAULT_MODE = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [WIDTH-1:0] div,
  input  logic             mode,
  output logic             y,
  output logic             tick,
  output logic [WIDTH-1:0] count
);

  typedef enum logic {
    MODE_PULSE  = 1'b0,
    MODE_SQUARE = 1'b1
  } mode_e;

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] div_q, div_d;
  mode_e            mode_q, mode_d;

  logic [WIDTH-1:0] ne;
  logic [WIDTH-1:0] last_phase;
  logic [WIDTH:0]   high_len;
  logic             at_last;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q <= '0;
      div_q   <= WIDTH'(DEFAULT_DIV);
      mode_q  <= mode_e'(1'(DEFAULT_MODE));
    end else begin
      count_q <= count_d;
      div_q   <= div_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    ne         = (div_q == '0) ? WIDTH'(1) : div_q;
    last_phase = ne - WIDTH'(1);
    at_last    = (count_q == last_phase);
    // One extra bit so that ne = 2^WIDTH-1 rounds up without wrapping.
    high_len   = ({1'b0, ne} + (WIDTH+1)'(1)) >> 1;

    count_d = count_q;
    div_d   = div_q;
    mode_d  = mode_q;
    if (en) begin
      if (at_last) begin
        count_d = '0;
        div_d   = div;
        mode_d  = mode_e'(mode);
      end else begin
        count_d = count_q + WIDTH'(1);
      end
    end

    // Moore decode of registered state; ne == 1 yields constant 1 in both modes.
    if (mode_q == MODE_SQUARE) begin
      y = ({1'b0, count_q} < high_len);
    end else begin
      y = (count_q == '0);
    end
    tick  = en && at_last;
    count = count_q;
  end

endmodule

// File: tb/tb_divide_by_n_fsm.sv
// Directed bench for divide_by_n_fsm: a vector table for single-cycle behaviour plus
// hand-written sequences for square mode, ratio change, wide ratio and mid-period reset.
module tb_divide_by_n_fsm;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       en = 1'b1;
  logic [7:0] div = 8'd4;
  logic       mode = 1'b0;
  logic       y, tick;
  logic [7:0] count;
  logic       y2, tick2;
  logic [7:0] count2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  divide_by_n_fsm #(.WIDTH(8), .DEFAULT_DIV(4), .DEFAULT_MODE(0)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .div(div), .mode(mode),
    .y(y), .tick(tick), .count(count)
  );

  // Second instance resets into square mode for the square-wave start-up sequence.
  divide_by_n_fsm #(.WIDTH(8), .DEFAULT_DIV(4), .DEFAULT_MODE(1)) dut_sq (
    .clk(clk), .reset_n(reset_n), .en(en), .div(div), .mode(mode),
    .y(y2), .tick(tick2), .count(count2)
  );

  typedef struct {
    logic       rst_n;
    logic       en;
    logic [7:0] div;
    logic       mode;
    logic       y;
    logic       tick;
    logic [7:0] count;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic e, input logic [7:0] d, input logic m,
                     input logic ey, input logic et, input logic [7:0] ec);
    vec_t v;
    v.rst_n = r; v.en = e; v.div = d; v.mode = m;
    v.y = ey; v.tick = et; v.count = ec;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Apply inputs away from the edge, clock once, sample 1 ns after the edge.
  task automatic step(input logic r, input logic e, input logic [7:0] d, input logic m);
    @(negedge clk);
    reset_n = r; en = e; div = d; mode = m;
    @(posedge clk);
    #1;
    $display("t=%0t rst_n=%0b en=%0b div=%0d mode=%0b -> y=%0b tick=%0b count=%0d",
             $time, r, e, d, m, y, tick, count);
  endtask

  initial begin
    int sq_c[10]  = '{1, 2, 3, 0, 1, 2, 3, 4, 0, 1};
    int sq_y[10]  = '{1, 0, 0, 1, 1, 1, 0, 0, 1, 1};
    int sq_t[10]  = '{0, 0, 1, 0, 0, 0, 0, 1, 0, 0};
    int mc_c[12]  = '{1, 2, 3, 4, 5, 0, 1, 2, 0, 1, 2, 0};
    int mc_t[12]  = '{0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0};
    int rs_c[11]  = '{1, 2, 3, 0, 1, 2, 3, 4, 5, 6, 0};
    int rs_t[11]  = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0};
    int highs, lows, bad_cnt, bad_tick;

    // Square-mode start: default ratio 4 for one period, then div=5 loaded at the wrap.
    step(0, 1, 8'd5, 1);
    step(0, 1, 8'd5, 1);
    chk("sq_reset_y", y2, 1);
    chk("sq_reset_count", count2, 0);
    chk("sq_reset_tick", tick2, 0);
    for (int i = 0; i < 10; i++) begin
      step(1, 1, 8'd5, 1);
      chk($sformatf("sq_count[%0d]", i), count2, sq_c[i]);
      chk($sformatf("sq_y[%0d]", i), y2, sq_y[i]);
      chk($sformatf("sq_tick[%0d]", i), tick2, sq_t[i]);
    end

    // Reset and pulse-mode N=4 run, then reset mid-period.
    add(0,1,8'd4,0, 1,0,0); add(0,1,8'd4,0, 1,0,0);
    add(1,1,8'd4,0, 0,0,1); add(1,1,8'd4,0, 0,0,2); add(1,1,8'd4,0, 0,1,3);
    add(1,1,8'd4,0, 1,0,0); add(1,1,8'd4,0, 0,0,1); add(1,1,8'd4,0, 0,0,2);
    add(1,1,8'd4,0, 0,1,3); add(1,1,8'd4,0, 1,0,0); add(1,1,8'd4,0, 0,0,1);
    add(0,1,8'd4,0, 1,0,0);
    // Enable dropped in the last phase: state and outputs freeze, tick forced low.
    add(1,1,8'd4,0, 0,0,1); add(1,1,8'd4,0, 0,0,2); add(1,1,8'd4,0, 0,1,3);
    add(1,0,8'd4,0, 0,0,3); add(1,0,8'd4,0, 0,0,3); add(1,0,8'd4,0, 0,0,3);
    add(1,1,8'd4,0, 1,0,0);
    // Degenerate ratios 0 and 1 in both modes, then back to 4.
    add(1,1,8'd0,0, 0,0,1); add(1,1,8'd0,0, 0,0,2); add(1,1,8'd0,0, 0,1,3);
    add(1,1,8'd0,0, 1,1,0); add(1,1,8'd0,0, 1,1,0); add(1,0,8'd0,0, 1,0,0);
    add(1,1,8'd1,0, 1,1,0); add(1,1,8'd1,1, 1,1,0); add(1,0,8'd1,1, 1,0,0);
    add(1,1,8'd4,0, 1,0,0);

    foreach (tbl[i]) begin
      step(tbl[i].rst_n, tbl[i].en, tbl[i].div, tbl[i].mode);
      chk($sformatf("vec%0d_y", i), y, tbl[i].y);
      chk($sformatf("vec%0d_tick", i), tick, tbl[i].tick);
      chk($sformatf("vec%0d_count", i), count, tbl[i].count);
    end

    // Load N=6, then request N=3 at count 2; the 6-cycle period must complete first.
    for (int i = 1; i <= 4; i++) begin
      step(1, 1, 8'd6, 0);
      chk($sformatf("ld6_count[%0d]", i), count, i % 4);
    end
    for (int i = 0; i < 12; i++) begin
      step(1, 1, (i < 2) ? 8'd6 : 8'd3, 0);
      chk($sformatf("mc_count[%0d]", i), count, mc_c[i]);
      chk($sformatf("mc_y[%0d]", i), y, (mc_c[i] == 0) ? 1 : 0);
      chk($sformatf("mc_tick[%0d]", i), tick, mc_t[i]);
    end

    // N=255 square: 128 high, 127 low, tick only on phase 254.
    step(1, 1, 8'd255, 1); chk("w_pre_count1", count, 1);
    step(1, 1, 8'd255, 1); chk("w_pre_tick", tick, 1);
    step(1, 1, 8'd255, 1); chk("w_load_count", count, 0);
    highs = 0; lows = 0; bad_cnt = 0; bad_tick = 0;
    for (int i = 0; i < 255; i++) begin
      if (i > 0) step(1, 1, 8'd255, 1);
      if (count != 8'(i)) bad_cnt++;
      if (tick != (i == 254)) bad_tick++;
      if (y) highs++; else lows++;
    end
    chk("w_high_cycles", highs, 128);
    chk("w_low_cycles", lows, 127);
    chk("w_count_seq_errs", bad_cnt, 0);
    chk("w_tick_seq_errs", bad_tick, 0);

    // Load N=7 pulse, run to count 5, reset: ratio reverts to 4 until the next wrap.
    step(1, 1, 8'd7, 0);
    chk("n7_wrap_count", count, 0);
    chk("n7_wrap_y", y, 1);
    for (int i = 1; i <= 5; i++) step(1, 1, 8'd7, 0);
    chk("n7_count5", count, 5);
    step(0, 1, 8'd7, 0);
    chk("rst_mid_count", count, 0);
    chk("rst_mid_y", y, 1);
    chk("rst_mid_tick", tick, 0);
    for (int i = 0; i < 11; i++) begin
      step(1, 1, 8'd7, 0);
      chk($sformatf("rs_count[%0d]", i), count, rs_c[i]);
      chk($sformatf("rs_tick[%0d]", i), tick, rs_t[i]);
      chk($sformatf("rs_y[%0d]", i), y, (rs_c[i] == 0) ? 1 : 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
